// File: rtl/tomasulo_pkg.sv
// Constants and tag helpers shared by the CDB arbiter and the reservation stations.
package tomasulo_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAG_W  = 3;
    localparam int DEF_REG_W  = 3;

    localparam logic [DEF_TAG_W-1:0]  TAG_NONE = 3'b000;
    localparam logic [DEF_DATA_W-1:0] VAL_NONE = 16'hFFF0;

    // Tag 0 is reserved for "no producer", so station i carries tag i+1.
    function automatic logic [DEF_TAG_W-1:0] rs_to_tag(input logic [DEF_TAG_W-1:0] rs);
        return rs + 1'b1;
    endfunction

    function automatic logic [DEF_TAG_W-1:0] tag_to_rs(input logic [DEF_TAG_W-1:0] tag);
        return tag - 1'b1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or after ptr, wrapping.
module rr_pick #(
    parameter int N_RS  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_RS-1:0]  elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win,
    output logic             found
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest eligible station is assigned last.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = N_RS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_RS;
            if (elig[idx]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among reservation stations, one
// registered broadcast per cycle, never the same station on consecutive cycles.
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int N_RS   = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [N_RS-1:0]         Req,
    input  logic [N_RS*DATA_W-1:0]  Result,
    input  logic [N_RS*REG_W-1:0]   R_target,
    input  logic                    Flush,
    output logic [N_RS-1:0]         CDB_confirm,
    output logic                    CDB_valid,
    output logic [TAG_W-1:0]        CDB_tag,
    output logic [DATA_W-1:0]       CDB_data,
    output logic [REG_W-1:0]        CDB_rtarget
);

    localparam int IDX_W = (N_RS > 1) ? $clog2(N_RS) : 1;

    typedef enum logic {IDLE, BCAST} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic             found;
    logic [N_RS-1:0]  last_mask;
    logic [N_RS-1:0]  elig;

    // The station on the bus this cycle still has Req high (it drops next cycle), so mask it.
    assign last_mask = (state == BCAST) ? CDB_confirm : '0;
    assign elig      = Req & ~last_mask;

    rr_pick #(
        .N_RS  (N_RS),
        .IDX_W (IDX_W)
    ) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .win   (win),
        .found (found)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            ptr         <= '0;
            CDB_valid   <= 1'b0;
            CDB_confirm <= '0;
            CDB_tag     <= TAG_W'(TAG_NONE);
            CDB_data    <= DATA_W'(VAL_NONE);
            CDB_rtarget <= '0;
        end else if (!Flush && found) begin
            state       <= BCAST;
            ptr         <= (win == IDX_W'(N_RS - 1)) ? '0 : win + 1'b1;
            CDB_valid   <= 1'b1;
            CDB_confirm <= N_RS'(1) << win;
            CDB_tag     <= TAG_W'(rs_to_tag(DEF_TAG_W'(win)));
            CDB_data    <= Result[win*DATA_W +: DATA_W];
            CDB_rtarget <= R_target[win*REG_W +: REG_W];
        end else begin
            // Flush or nothing eligible: bus idles, ptr holds its position.
            state       <= IDLE;
            CDB_valid   <= 1'b0;
            CDB_confirm <= '0;
            CDB_tag     <= TAG_W'(TAG_NONE);
            CDB_data    <= DATA_W'(VAL_NONE);
            CDB_rtarget <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: stimulus queues expected bus state per edge,
// a monitor pops and compares one cycle's outputs after each rising edge.
module tb_cdb_arbiter;

    logic        Clock;
    logic        Reset;
    logic [3:0]  Req;
    logic [63:0] Result;
    logic [11:0] R_target;
    logic        Flush;
    logic [3:0]  CDB_confirm;
    logic        CDB_valid;
    logic [2:0]  CDB_tag;
    logic [15:0] CDB_data;
    logic [2:0]  CDB_rtarget;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [3:0]  c;
        logic [2:0]  t;
        logic [15:0] d;
        logic [2:0]  r;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];

    cdb_arbiter #(.N_RS(4), .DATA_W(16), .TAG_W(3), .REG_W(3)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Req         (Req),
        .Result      (Result),
        .R_target    (R_target),
        .Flush       (Flush),
        .CDB_confirm (CDB_confirm),
        .CDB_valid   (CDB_valid),
        .CDB_tag     (CDB_tag),
        .CDB_data    (CDB_data),
        .CDB_rtarget (CDB_rtarget)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic exp_t idle();
        exp_t e;
        e.v = 1'b0; e.c = 4'b0000; e.t = 3'd0; e.d = 16'hFFF0; e.r = 3'd0;
        return e;
    endfunction

    function automatic exp_t g(input int w);
        exp_t e;
        e.v = 1'b1;
        e.c = 4'b0001 << w;
        e.t = 3'(w + 1);
        e.d = Result[w*16 +: 16];
        e.r = R_target[w*3 +: 3];
        return e;
    endfunction

    task automatic check_rec(input string nm, input exp_t e);
        checks++;
        if (CDB_valid !== e.v || CDB_confirm !== e.c || CDB_tag !== e.t ||
            CDB_data !== e.d || CDB_rtarget !== e.r) begin
            errors++;
            $display("FAIL %s got v=%0b conf=%b tag=%0d data=%h rt=%0d want v=%0b conf=%b tag=%0d data=%h rt=%0d",
                     nm, CDB_valid, CDB_confirm, CDB_tag, CDB_data, CDB_rtarget,
                     e.v, e.c, e.t, e.d, e.r);
        end
    endtask

    task automatic set_slot(input int i, input logic [15:0] d, input logic [2:0] r);
        Result[i*16 +: 16] = d;
        R_target[i*3 +: 3] = r;
    endtask

    // Drive inputs for the next edge and queue what that edge must produce.
    task automatic step(input logic [3:0] req, input logic fl, input exp_t e, input string nm);
        Req   = req;
        Flush = fl;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge Clock);
    endtask

    // Monitor
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                check_rec(nm, e);
            end else if (CDB_valid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bcast got v=%0b conf=%b tag=%0d want v=0",
                         CDB_valid, CDB_confirm, CDB_tag);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t held;
        Reset = 1'b1;
        Flush = 1'b0;
        Req   = 4'b1111;
        for (int i = 0; i < 4; i++) set_slot(i, 16'hA000 + 16'(i) * 16'h0111, 3'(7 - i));

        #2 Reset = 1'b0;
        #1 check_rec("reset_async", idle());
        @(negedge Clock);
        @(negedge Clock);
        check_rec("reset_hold", idle());

        // Release: all four keep requesting, order 0,1,2,3,0
        Reset = 1'b1;
        step(4'b1111, 1'b0, g(0), "rr_0");
        step(4'b1111, 1'b0, g(1), "rr_1");
        step(4'b1111, 1'b0, g(2), "rr_2");
        step(4'b1111, 1'b0, g(3), "rr_3");
        step(4'b1111, 1'b0, g(0), "rr_0b");
        step(4'b0000, 1'b0, idle(), "drain_1");
        step(4'b1000, 1'b0, g(3), "align_3");
        step(4'b0000, 1'b0, idle(), "drain_2");

        // 0101 with each station dropping the cycle after its confirm
        step(4'b0101, 1'b0, g(0), "p0101_a");
        step(4'b0101, 1'b0, g(2), "p0101_b");
        step(4'b0100, 1'b0, idle(), "p0101_c");
        step(4'b0000, 1'b0, idle(), "p0101_d");

        // Lone continuous requester only gets alternate cycles
        set_slot(2, 16'h1234, 3'd5);
        step(4'b0100, 1'b0, g(2), "solo_a");
        step(4'b0100, 1'b0, idle(), "solo_b");
        step(4'b0100, 1'b0, g(2), "solo_c");
        step(4'b0100, 1'b0, idle(), "solo_d");
        step(4'b0100, 1'b0, g(2), "solo_e");
        step(4'b0000, 1'b0, idle(), "solo_end");

        // Flush beats Req; ptr is left alone
        step(4'b0010, 1'b1, idle(), "flush_req");
        step(4'b0010, 1'b0, g(1), "post_flush");
        step(4'b0000, 1'b0, idle(), "drain_3");
        step(4'b1111, 1'b0, g(2), "ptr_a");
        step(4'b1111, 1'b1, idle(), "flush_bcast");
        step(4'b1111, 1'b0, g(3), "ptr_b");
        step(4'b0000, 1'b0, idle(), "drain_4");

        // Result captured at grant; async reset mid-broadcast restarts from ptr 0
        step(4'b0010, 1'b0, g(1), "pre_rst");
        held = g(1);
        set_slot(1, 16'h0BAD, 3'd0);
        Req = 4'b0000;
        #1 check_rec("capture", held);
        Reset = 1'b0;
        #1 check_rec("rst_mid", idle());
        @(negedge Clock);
        Reset = 1'b1;
        step(4'b1111, 1'b0, g(0), "rst_ptr");
        step(4'b0000, 1'b0, idle(), "end");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clock);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
